// File: rtl/scan_pkg.sv
// Shared types, widths and helpers for the pressure-matrix row scan sequencer.
package scan_pkg;

    localparam int unsigned ROW_W   = 5;
    localparam int unsigned DEMUX_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BREAK,
        ST_SETTLE,
        ST_START,
        ST_WAIT,
        ST_NEXT,
        ST_GAP
    } scan_state_t;

    // Timer must hold the largest load value itself, hence the +1 before clog2.
    function automatic int unsigned timer_width(input int unsigned settle,
                                                input int unsigned timeout,
                                                input int unsigned gap);
        int unsigned m;
        m = settle;
        if (timeout > m) m = timeout;
        if (gap > m) m = gap;
        return $clog2(m + 1);
    endfunction

    function automatic logic [DEMUX_W-1:0] row_onehot(input logic [ROW_W-1:0] idx);
        return DEMUX_W'(1) << idx;
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Loadable down-counter shared by the settle, done-timeout and frame-gap phases.
module scan_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_core,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_value,
    output logic             o_expired_c
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk_core) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    // A load of N gives N counted cycles; the last one reads 1.
    assign o_expired_c = (r_count == WIDTH'(1));

endmodule

// File: rtl/row_scan_sequencer.sv
// Row scan sequencer: one-hot row select, settle, shared ADC start, dual done wait.
module row_scan_sequencer
    import scan_pkg::*;
#(
    parameter int unsigned NUM_ROWS         = 32,
    parameter int unsigned SETTLE_CYCLES    = 200,
    parameter int unsigned TIMEOUT_CYCLES   = 100000,
    parameter int unsigned FRAME_GAP_CYCLES = 0
) (
    input  logic               clk_core,
    input  logic               reset,
    input  logic               enable,
    input  logic               adc1_done,
    input  logic               adc2_done,
    input  logic               err_clr,
    output logic [DEMUX_W-1:0] deMUX_Y,
    output logic               adc_start,
    output logic [ROW_W-1:0]   row_idx,
    output logic               row_valid,
    output logic               frame_head,
    output logic               timeout_err,
    output logic               busy
);

    localparam int unsigned    TIMER_W  = timer_width(SETTLE_CYCLES, TIMEOUT_CYCLES,
                                                      FRAME_GAP_CYCLES);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);
    localparam bit             HAS_GAP  = (FRAME_GAP_CYCLES != 0);

    scan_state_t        r_state;
    logic [ROW_W-1:0]   r_row_idx;
    logic [DEMUX_W-1:0] r_demux;
    logic               r_adc_start;
    logic               r_row_valid;
    logic               r_frame_head;
    logic               r_timeout_err;
    logic               r_busy;
    logic               r_done1;
    logic               r_done2;

    logic               w_timer_load;
    logic [TIMER_W-1:0] w_timer_val;
    logic               w_timer_expired;
    logic               w_both_done;
    logic               w_timeout;

    // Timer load select: settle in BREAK, timeout in START, gap on the last NEXT.
    always_comb begin
        w_timer_load = 1'b0;
        w_timer_val  = '0;
        case (r_state)
            ST_BREAK: begin
                w_timer_load = 1'b1;
                w_timer_val  = TIMER_W'(SETTLE_CYCLES);
            end
            ST_START: begin
                w_timer_load = 1'b1;
                w_timer_val  = TIMER_W'(TIMEOUT_CYCLES);
            end
            ST_NEXT: begin
                w_timer_load = (r_row_idx == LAST_ROW);
                w_timer_val  = TIMER_W'(FRAME_GAP_CYCLES);
            end
            default: ;
        endcase
    end

    // Strobes landing this cycle count toward completion alongside the latches.
    assign w_both_done = (r_done1 | adc1_done) & (r_done2 | adc2_done);
    assign w_timeout   = (r_state == ST_WAIT) & ~w_both_done & w_timer_expired;

    scan_timer #(
        .WIDTH(TIMER_W)
    ) u_timer (
        .clk_core   (clk_core),
        .reset      (reset),
        .i_load     (w_timer_load),
        .i_value    (w_timer_val),
        .o_expired_c(w_timer_expired)
    );

    always_ff @(posedge clk_core) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_row_idx     <= '0;
            r_demux       <= '0;
            r_adc_start   <= 1'b0;
            r_row_valid   <= 1'b0;
            r_frame_head  <= 1'b0;
            r_timeout_err <= 1'b0;
            r_busy        <= 1'b0;
            r_done1       <= 1'b0;
            r_done2       <= 1'b0;
        end else begin
            r_adc_start  <= 1'b0;
            r_row_valid  <= 1'b0;
            r_frame_head <= 1'b0;

            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end else if (err_clr) begin
                r_timeout_err <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (enable) begin
                        r_state      <= ST_BREAK;
                        r_row_idx    <= '0;
                        r_frame_head <= 1'b1;
                        r_busy       <= 1'b1;
                    end
                end
                ST_BREAK: begin
                    r_done1 <= 1'b0;
                    r_done2 <= 1'b0;
                    r_demux <= row_onehot(r_row_idx);
                    r_state <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (w_timer_expired) begin
                        r_adc_start <= 1'b1;
                        r_state     <= ST_START;
                    end
                end
                ST_START: begin
                    r_done1 <= r_done1 | adc1_done;
                    r_done2 <= r_done2 | adc2_done;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_done1 <= r_done1 | adc1_done;
                    r_done2 <= r_done2 | adc2_done;
                    if (w_both_done) begin
                        r_row_valid <= 1'b1;
                        r_state     <= ST_NEXT;
                    end else if (w_timer_expired) begin
                        r_state <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    r_demux <= '0;
                    if (r_row_idx < LAST_ROW) begin
                        r_row_idx <= r_row_idx + ROW_W'(1);
                        r_state   <= ST_BREAK;
                    end else begin
                        r_row_idx <= '0;
                        if (HAS_GAP) begin
                            r_state <= ST_GAP;
                        end else if (enable) begin
                            r_state      <= ST_BREAK;
                            r_frame_head <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                ST_GAP: begin
                    if (w_timer_expired) begin
                        if (enable) begin
                            r_state      <= ST_BREAK;
                            r_frame_head <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_demux <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign deMUX_Y     = r_demux;
    assign adc_start   = r_adc_start;
    assign row_idx     = r_row_idx;
    assign row_valid   = r_row_valid;
    assign frame_head  = r_frame_head;
    assign timeout_err = r_timeout_err;
    assign busy        = r_busy;

endmodule
